// File: rtl/trivium_stream_if.sv
// trivium_stream_if
// Data-path handshake bundle for the Trivium keystream engine.
//   Din      W   data word into the engine
//   Din_vld  1   Din is valid
//   Din_rdy  1   engine accepts Din this cycle (when Din_vld is also high)
//   Dout     W   Din XOR keystream
//   Dout_vld 1   Dout is valid
//   Dout_rdy 1   downstream consumes Dout this cycle (when Dout_vld is also high)
// master: the side that supplies Din and consumes Dout.
// slave : the engine.
interface trivium_stream_if #(
    parameter int W = 8
);
    logic [W-1:0] Din;
    logic         Din_vld;
    logic         Din_rdy;
    logic [W-1:0] Dout;
    logic         Dout_vld;
    logic         Dout_rdy;

    modport master (
        output Din, Din_vld, Dout_rdy,
        input  Din_rdy, Dout, Dout_vld
    );

    modport slave (
        input  Din, Din_vld, Dout_rdy,
        output Din_rdy, Dout, Dout_vld
    );
endinterface

// File: rtl/trivium_stream.sv
// trivium_stream
// Trivium keystream engine producing W keystream bits per clock. Holds an
// 80-bit key, loads an 80-bit IV, runs the initialisation rounds, then XORs
// W-bit data words with keystream under valid/ready handshakes.
// Ports:
//   CLK, RSTn   clock, synchronous active-low reset
//   EN          clock enable; when low nothing changes and no handshake completes
//   Kin, Krdy   key value and load strobe (IDLE only)
//   IVin, Irdy  IV value and session start strobe (IDLE only, needs Kvld)
//   ds          data handshake bundle (slave side)
//   Kvld        a key has been loaded since reset
//   BSY         session active (INIT, STREAM or DRAIN)
//   Done        one-cycle pulse when the last word of a session is consumed
//
// state  | meaning
// IDLE   | waiting for key loads and a start strobe
// INIT   | running initialisation rounds, keystream discarded
// STREAM | accepting data words, one keystream word per accepted word
// DRAIN  | all words accepted, waiting for the last Dout to be consumed
module trivium_stream #(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152,
    parameter int MAX_WORDS   = 64
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            EN,
    input  logic [79:0]     Kin,
    input  logic            Krdy,
    input  logic [79:0]     IVin,
    input  logic            Irdy,
    trivium_stream_if.slave ds,
    output logic            Kvld,
    output logic            BSY,
    output logic            Done
);
    localparam int INIT_CYC = INIT_ROUNDS / W;
    localparam int ICW      = $clog2(INIT_CYC + 1);
    localparam int WCW      = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [287:0]   s_q, s_d, s_adv;
    logic [79:0]    key_q, key_d;
    logic           kvld_q, kvld_d;
    logic [ICW-1:0] rcnt_q, rcnt_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           dout_vld_q, dout_vld_d;
    logic           done_q, done_d;
    logic [W-1:0]   ks;
    logic           din_rdy;
    logic           accept;
    logic           consume;

    // Host registers hold byte 0 in the top byte; the cipher wants it at the bottom.
    function automatic logic [79:0] byte_rev(input logic [79:0] v);
        logic [79:0] r;
        r = '0;
        for (int b = 0; b < 10; b++) begin
            r[8*b +: 8] = v[8*(9-b) +: 8];
        end
        return r;
    endfunction

    // W chained rounds; the first round's output lands in the MSB of ks.
    always_comb begin
        logic [287:0] s;
        logic         t1, t2, t3;
        s   = s_q;
        t1  = 1'b0;
        t2  = 1'b0;
        t3  = 1'b0;
        ks  = '0;
        for (int i = 0; i < W; i++) begin
            t1 = s[65] ^ s[92];
            t2 = s[161] ^ s[176];
            t3 = s[242] ^ s[287];
            ks[W-1-i] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[90] & s[91]) ^ s[170];
            t2 = t2 ^ (s[174] & s[175]) ^ s[263];
            t3 = t3 ^ (s[285] & s[286]) ^ s[68];
            s  = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        s_adv = s;
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        key_d      = key_q;
        kvld_d     = kvld_q;
        rcnt_d     = rcnt_q;
        wcnt_d     = wcnt_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        done_d     = 1'b0;
        din_rdy    = 1'b0;
        accept     = 1'b0;
        consume    = EN & dout_vld_q & ds.Dout_rdy;

        case (state_q)
            ST_IDLE: begin
                // A key load wins over a simultaneous start strobe.
                if (Krdy) begin
                    key_d  = byte_rev(Kin);
                    kvld_d = 1'b1;
                end else if (Irdy && kvld_q) begin
                    s_d     = {3'b111, 112'd0, byte_rev(IVin), 13'd0, key_q};
                    rcnt_d  = ICW'(INIT_CYC);
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                s_d    = s_adv;
                rcnt_d = rcnt_q - ICW'(1);
                if (rcnt_q == ICW'(1)) begin
                    state_d = ST_STREAM;
                    wcnt_d  = '0;
                end
            end
            ST_STREAM: begin
                din_rdy = EN & (~dout_vld_q | ds.Dout_rdy);
                accept  = din_rdy & ds.Din_vld;
                if (consume) begin
                    dout_vld_d = 1'b0;
                end
                if (accept) begin
                    dout_d     = ds.Din ^ ks;
                    dout_vld_d = 1'b1;
                    s_d        = s_adv;
                    wcnt_d     = wcnt_q + WCW'(1);
                    if (wcnt_q == WCW'(MAX_WORDS - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (consume) begin
                    dout_vld_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            key_q      <= '0;
            kvld_q     <= 1'b0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (EN) begin
            state_q    <= state_d;
            s_q        <= s_d;
            key_q      <= key_d;
            kvld_q     <= kvld_d;
            rcnt_q     <= rcnt_d;
            wcnt_q     <= wcnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            done_q     <= done_d;
        end
    end

    assign ds.Din_rdy  = din_rdy;
    assign ds.Dout     = dout_q;
    assign ds.Dout_vld = dout_vld_q;
    assign Kvld        = kvld_q;
    assign BSY         = (state_q != ST_IDLE);
    assign Done        = done_q;
endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream
// Drives trivium_stream through key/IV loads and data sessions with random
// handshakes, checking outputs against a bit-serial Trivium reference.
module tb_trivium_stream;
    localparam int W           = 8;
    localparam int INIT_ROUNDS = 1152;
    localparam int MAX_WORDS   = 64;
    localparam int INIT_CYC    = INIT_ROUNDS / W;

    logic        CLK  = 1'b0;
    logic        RSTn = 1'b0;
    logic        EN   = 1'b1;
    logic        Krdy = 1'b0;
    logic        Irdy = 1'b0;
    logic [79:0] Kin  = '0;
    logic [79:0] IVin = '0;
    logic        Kvld, BSY, Done;

    trivium_stream_if #(.W(W)) ds();

    trivium_stream #(
        .W(W), .INIT_ROUNDS(INIT_ROUNDS), .MAX_WORDS(MAX_WORDS)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN),
        .Kin(Kin), .Krdy(Krdy), .IVin(IVin), .Irdy(Irdy),
        .ds(ds),
        .Kvld(Kvld), .BSY(BSY), .Done(Done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: bit-serial Trivium ----------------
    bit           ksb[MAX_WORDS*W];
    logic [W-1:0] ks_words[MAX_WORDS];

    // Three shift registers a(93), b(84), c(111), 1-based as in the cipher description.
    task automatic gen_words(input logic [79:0] kraw, input logic [79:0] ivraw, input int n_init);
        bit a[1:93];
        bit b[1:84];
        bit c[1:111];
        logic [79:0] k, v;
        bit t1, t2, t3, z;
        for (int i = 0; i < 10; i++) begin
            k[8*i +: 8] = kraw[8*(9-i) +: 8];
            v[8*i +: 8] = ivraw[8*(9-i) +: 8];
        end
        for (int i = 1; i <= 93; i++)  a[i] = (i <= 80) ? k[i-1] : 1'b0;
        for (int i = 1; i <= 84; i++)  b[i] = (i <= 80) ? v[i-1] : 1'b0;
        for (int i = 1; i <= 111; i++) c[i] = (i >= 109);
        for (int r = 0; r < n_init + MAX_WORDS*W; r++) begin
            t1 = a[66] ^ a[93];
            t2 = b[69] ^ b[84];
            t3 = c[66] ^ c[111];
            z  = t1 ^ t2 ^ t3;
            if (r >= n_init) ksb[r - n_init] = z;
            t1 = t1 ^ (a[91] & a[92]) ^ b[78];
            t2 = t2 ^ (b[82] & b[83]) ^ c[87];
            t3 = t3 ^ (c[109] & c[110]) ^ a[69];
            for (int i = 93; i > 1; i--)  a[i] = a[i-1];
            for (int i = 84; i > 1; i--)  b[i] = b[i-1];
            for (int i = 111; i > 1; i--) c[i] = c[i-1];
            a[1] = t3;
            b[1] = t1;
            c[1] = t2;
        end
        for (int w = 0; w < MAX_WORDS; w++)
            for (int j = 0; j < W; j++)
                ks_words[w][W-1-j] = ksb[w*W + j];
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got[MAX_WORDS];
    int  acc_idx = 0;
    int  ncons = 0;
    int  got_n = 0;
    int  done_cyc = 0;
    bit  done_seen = 0;
    bit  done_exp = 0;
    bit  chk_on = 0;

    always @(negedge CLK) begin
        bit cons, acc, done_nxt;
        if (chk_on) begin
            check("done", 64'(Done), 64'(done_exp));
            check("dout_vld", 64'(ds.Dout_vld), 64'(exp_q.size() != 0));
            if (ds.Dout_vld && exp_q.size() != 0)
                check("dout", 64'(ds.Dout), 64'(exp_q[0]));
            if (ds.Dout_vld && !ds.Dout_rdy)
                check("din_rdy_backpressure", 64'(ds.Din_rdy), 64'(0));
            if (ds.Din_rdy)
                check("din_rdy_needs_bsy", 64'(BSY), 64'(1));
        end
        if (Done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        cons = EN & ds.Dout_vld & ds.Dout_rdy;
        acc  = EN & ds.Din_vld & ds.Din_rdy;
        if (!RSTn) begin
            exp_q.delete();
            done_exp = 1'b0;
            ncons    = 0;
        end else if (EN) begin
            done_nxt = 1'b0;
            if (cons && exp_q.size() != 0) begin
                if (got_n < MAX_WORDS) got[got_n] = ds.Dout;
                got_n++;
                void'(exp_q.pop_front());
                ncons++;
                if (ncons == MAX_WORDS) done_nxt = 1'b1;
            end
            if (acc) begin
                exp_q.push_back(ds.Din ^ ((acc_idx < MAX_WORDS) ? ks_words[acc_idx] : '0));
                acc_idx++;
            end
            done_exp = done_nxt;
        end
    end

    // ---------------- stimulus ----------------
    logic [79:0]  cur_key = '0;
    logic [W-1:0] din_words[MAX_WORDS];
    logic [W-1:0] ref0[MAX_WORDS];
    logic [W-1:0] ct[MAX_WORDS];

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    task automatic run_session(input logic [79:0] iv, input bit rnd, input bit gaps,
                               input bit poke, input string tag);
        int c_irdy, first_rdy, off, idx;
        gen_words(cur_key, iv, INIT_ROUNDS);
        acc_idx = 0; ncons = 0; got_n = 0; done_seen = 1'b0;
        idx = 0; first_rdy = -1;
        @(posedge CLK); #1;
        IVin = iv; Irdy = 1'b1; EN = 1'b1;
        ds.Din_vld = 1'b1; ds.Dout_rdy = 1'b1; ds.Din = din_words[0];
        c_irdy = cyc;
        for (int n = 0; n < 4000 && !done_seen; n++) begin
            @(posedge CLK); #1;
            off  = cyc - c_irdy;
            Irdy = poke && (off == 160);
            Krdy = poke && (off == 160);
            Kin  = ~cur_key;
            IVin = ~iv;
            EN   = !(gaps && ((off >= 50 && off < 60) || (off >= 180 && off < 190)));
            ds.Dout_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ds.Din_vld  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            ds.Din      = (idx < MAX_WORDS) ? din_words[idx] : '0;
            @(negedge CLK);
            if (off == 1) check({tag, "_bsy_start"}, 64'(BSY), 64'(1));
            if (ds.Din_rdy && first_rdy < 0) first_rdy = off;
            if (EN && ds.Din_vld && ds.Din_rdy) idx++;
        end
        Krdy = 1'b0; Irdy = 1'b0; EN = 1'b1; ds.Din_vld = 1'b0; ds.Dout_rdy = 1'b1;
        check({tag, "_done_seen"}, 64'(done_seen), 64'(1));
        check({tag, "_first_din_rdy"}, 64'(first_rdy), 64'(INIT_CYC + 1 + (gaps ? 10 : 0)));
        if (!rnd)
            check({tag, "_done_latency"}, 64'(done_cyc - c_irdy),
                  64'(INIT_CYC + MAX_WORDS + 2 + (gaps ? 20 : 0)));
        check({tag, "_words_out"}, 64'(got_n), 64'(MAX_WORDS));
        check({tag, "_words_in"}, 64'(idx), 64'(MAX_WORDS));
        @(posedge CLK); @(negedge CLK);
        check({tag, "_bsy_end"}, 64'(BSY), 64'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [79:0] k2, ivr;
        ds.Din = '0; ds.Din_vld = 1'b0; ds.Dout_rdy = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RSTn = 1'b1;
        chk_on = 1'b1;
        @(negedge CLK);
        check("rst_kvld", 64'(Kvld), 64'(0));
        check("rst_bsy", 64'(BSY), 64'(0));
        check("rst_done", 64'(Done), 64'(0));
        check("rst_dout", 64'(ds.Dout), 64'(0));
        check("rst_din_rdy", 64'(ds.Din_rdy), 64'(0));

        // Pin the reference: from the load state with zero key/IV and no
        // initialisation, the first four keystream bits are 1,1,1,0.
        gen_words(80'd0, 80'd0, 0);
        check("model_raw_bits", 64'({ksb[0], ksb[1], ksb[2], ksb[3]}), 64'(4'b1110));
        check("model_pack_msb", 64'(ks_words[0][W-1 -: 4]), 64'(4'b1110));

        // Irdy with no key loaded is ignored.
        @(posedge CLK); #1 Irdy = 1'b1;
        @(posedge CLK); #1 Irdy = 1'b0;
        @(negedge CLK);
        check("irdy_nokey_bsy", 64'(BSY), 64'(0));
        check("irdy_nokey_kvld", 64'(Kvld), 64'(0));

        // Key load: Kvld follows one cycle later.
        @(posedge CLK); #1 Krdy = 1'b1; Kin = 80'd0; cur_key = 80'd0;
        @(negedge CLK);
        check("kvld_same_cycle", 64'(Kvld), 64'(0));
        @(posedge CLK); #1 Krdy = 1'b0;
        @(negedge CLK);
        check("kvld_next_cycle", 64'(Kvld), 64'(1));

        // Golden session: zero key/IV, zero data -> raw keystream.
        for (int i = 0; i < MAX_WORDS; i++) din_words[i] = '0;
        run_session(80'd0, 1'b0, 1'b0, 1'b0, "gold");
        ref0 = got;
        for (int i = 0; i < MAX_WORDS; i++) check("gold_ks", 64'(ref0[i]), 64'(ks_words[i]));

        // Involution: all-ones plaintext differs from the zero run by all-ones.
        for (int i = 0; i < MAX_WORDS; i++) din_words[i] = '1;
        run_session(80'd0, 1'b0, 1'b0, 1'b0, "inv");
        ct = got;
        for (int i = 0; i < MAX_WORDS; i++) check("inv_xor", 64'(ct[i] ^ ref0[i]), 64'({W{1'b1}}));

        // Decrypt the ciphertext under random backpressure.
        din_words = ct;
        run_session(80'd0, 1'b1, 1'b0, 1'b0, "dec");
        for (int i = 0; i < MAX_WORDS; i++) check("dec_plain", 64'(got[i]), 64'({W{1'b1}}));

        // Random backpressure must not change the keystream.
        for (int i = 0; i < MAX_WORDS; i++) din_words[i] = '0;
        run_session(80'd0, 1'b1, 1'b0, 1'b0, "bp");
        for (int i = 0; i < MAX_WORDS; i++) check("bp_same", 64'(got[i]), 64'(ref0[i]));

        // EN gaps in INIT and STREAM: +10 cycles each, same output.
        run_session(80'd0, 1'b0, 1'b1, 1'b0, "en");
        for (int i = 0; i < MAX_WORDS; i++) check("en_same", 64'(got[i]), 64'(ref0[i]));

        // Krdy and Irdy together: key loads, no session.
        k2 = rand80();
        @(posedge CLK); #1 Krdy = 1'b1; Irdy = 1'b1; Kin = k2; IVin = rand80();
        @(posedge CLK); #1 Krdy = 1'b0; Irdy = 1'b0;
        cur_key = k2;
        @(negedge CLK);
        check("both_bsy", 64'(BSY), 64'(0));
        check("both_kvld", 64'(Kvld), 64'(1));
        @(posedge CLK); @(negedge CLK);
        check("both_bsy_later", 64'(BSY), 64'(0));

        // Random key/IV/data with Krdy/Irdy poked mid-stream (must be ignored).
        for (int i = 0; i < MAX_WORDS; i++) din_words[i] = W'($urandom);
        run_session(rand80(), 1'b1, 1'b0, 1'b1, "rnd");

        // Key survives: another IV on the same key, full throughput.
        for (int i = 0; i < MAX_WORDS; i++) din_words[i] = W'($urandom);
        run_session(rand80(), 1'b0, 1'b0, 1'b0, "keep");

        // Reset in STREAM aborts without Done and clears the key.
        ivr = rand80();
        gen_words(cur_key, ivr, INIT_ROUNDS);
        acc_idx = 0; ncons = 0; got_n = 0;
        @(posedge CLK); #1 Irdy = 1'b1; IVin = ivr; ds.Din_vld = 1'b1; ds.Dout_rdy = 1'b1; ds.Din = '0;
        @(posedge CLK); #1 Irdy = 1'b0;
        repeat (INIT_CYC + 20) @(posedge CLK);
        #1 RSTn = 1'b0;
        @(negedge CLK);
        check("abort_busy_before", 64'(BSY), 64'(1));
        @(posedge CLK); #1 RSTn = 1'b1;
        @(negedge CLK);
        check("abort_kvld", 64'(Kvld), 64'(0));
        check("abort_bsy", 64'(BSY), 64'(0));
        check("abort_done", 64'(Done), 64'(0));
        check("abort_dout", 64'(ds.Dout), 64'(0));
        check("abort_dout_vld", 64'(ds.Dout_vld), 64'(0));
        check("abort_din_rdy", 64'(ds.Din_rdy), 64'(0));
        @(posedge CLK); #1 Irdy = 1'b1;
        @(posedge CLK); #1 Irdy = 1'b0; ds.Din_vld = 1'b0;
        @(negedge CLK);
        check("abort_irdy_ignored", 64'(BSY), 64'(0));

        repeat (2) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
